pipelined_ripple_adder: RTL and testbench

// - Parametrised successor to the single-bit combinational full adder: WIDTH-bit a+b+cin, split into

---
 rtl/pipelined_ripple_adder.sv | 158 +++++++++++++++
 tb/tb_pipelined_ripple_adder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: WIDTH-bit a+b+cin split into STAGES carry-chained
// slices, one register stage per slice, valid/ready handshake with a global
// stall on output back-pressure.
// Optional feature macro: PIPELINED_ADDER_OVF_EN adds the signed-overflow
// output ovf, computed in the last slice and aligned with sum.
module pipelined_ripple_adder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SLICE = WIDTH / STAGES;

  // Reject configurations where the slices would not tile the operand exactly.
  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_ripple_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
  end

  // Per-stage state: valid, carry out of the slice, sum bits resolved so far,
  // and the operands carried forward for the slices still to be added.
  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
`ifdef PIPELINED_ADDER_OVF_EN
  logic             ovf_q;
  logic             ovf_d;
`endif

  logic             advance;
  logic             src_v;
  logic             src_c;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_sum;
  logic [SLICE:0]   part;

  // Global stall: everything moves only when the output slot is free or draining.
  always_comb begin
    advance  = out_ready | ~valid_q[STAGES-1];
    in_ready = advance;
  end

  // Slice adders: stage k adds its slice of the skewed operands to the carry
  // from stage k-1; all stages hold together when the pipeline is stalled.
  always_comb begin
    src_v   = 1'b0;
    src_c   = 1'b0;
    src_a   = '0;
    src_b   = '0;
    src_sum = '0;
    part    = '0;
`ifdef PIPELINED_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    for (int unsigned k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k];
      carry_d[k] = carry_q[k];
      sum_d[k]   = sum_q[k];
      a_d[k]     = a_q[k];
      b_d[k]     = b_q[k];
    end
    if (advance) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (k == 0) begin
          src_v   = in_valid;
          src_c   = cin;
          src_a   = a;
          src_b   = b;
          src_sum = '0;
        end else begin
          src_v   = valid_q[k-1];
          src_c   = carry_q[k-1];
          src_a   = a_q[k-1];
          src_b   = b_q[k-1];
          src_sum = sum_q[k-1];
        end
        part = {1'b0, src_a[k*SLICE +: SLICE]} + {1'b0, src_b[k*SLICE +: SLICE]}
             + {{SLICE{1'b0}}, src_c};
        valid_d[k]                  = src_v;
        carry_d[k]                  = part[SLICE];
        sum_d[k]                    = src_sum;
        sum_d[k][k*SLICE +: SLICE]  = part[SLICE-1:0];
        // Operands travel whole; bits below the current slice are dead and trimmed by synthesis.
        a_d[k]                      = src_a;
        b_d[k]                      = src_b;
`ifdef PIPELINED_ADDER_OVF_EN
        if (k == STAGES - 1) begin
          ovf_d = (src_a[WIDTH-1] == src_b[WIDTH-1]) & (part[SLICE-1] != src_a[WIDTH-1]);
        end
`endif
      end
    end
  end

  // Control and result registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
      end
`ifdef PIPELINED_ADDER_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        sum_q[k]   <= sum_d[k];
      end
`ifdef PIPELINED_ADDER_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  // Operand skew registers; contents are only meaningful alongside a valid beat.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      a_q[k] <= a_d[k];
      b_q[k] <= b_d[k];
    end
  end

  // Outputs come straight from the last stage.
  always_comb begin
    out_valid = valid_q[STAGES-1];
    sum       = sum_q[STAGES-1];
    cout      = carry_q[STAGES-1];
`ifdef PIPELINED_ADDER_OVF_EN
    ovf       = ovf_q;
`endif
  end

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder: directed cases plus a
// randomized stream checked against an arithmetic scoreboard.
module tb_pipelined_ripple_adder;
  parameter int unsigned S = 2;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PIPELINED_ADDER_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           passed = 0;
  bit           last_acc = 1'b0;
  bit           hold_pending = 1'b0;
  logic [W-1:0] hold_sum;
  logic         hold_cout;
  logic         hold_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t r;
    int   t;
    int   sx;
    int   sy;
    int   ss;
    t   = int'(x) + int'(y) + int'(c);
    r.s = W'(t % (1 << W));
    r.c = (t >= (1 << W));
    sx  = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy  = y[W-1] ? int'(y) - (1 << W) : int'(y);
    ss  = sx + sy + int'(c);
    r.o = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
    return r;
  endfunction

  // One clock: observe at negedge, update the scoreboard, return just after posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (hold_pending) begin
      chk("stall_sum_held", sum, hold_sum);
      chk("stall_cout_held", cout, hold_cout);
      chk("stall_valid_held", out_valid, 1);
`ifdef PIPELINED_ADDER_OVF_EN
      chk("stall_ovf_held", ovf, hold_ovf);
`endif
    end
    hold_pending = 1'b0;
    last_acc     = 1'b0;
    if (rst === 1'b1) begin
      sb.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready) begin
        if (sb.size() == 0) begin
          chk("out_unexpected", out_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("sum", sum, e.s);
          chk("cout", cout, e.c);
`ifdef PIPELINED_ADDER_OVF_EN
          chk("ovf", ovf, e.o);
`endif
        end
      end
      if (out_valid === 1'b1 && !out_ready) begin
        hold_pending = 1'b1;
        hold_sum     = sum;
        hold_cout    = cout;
`ifdef PIPELINED_ADDER_OVF_EN
        hold_ovf     = ovf;
`endif
        chk("in_ready_stalled", in_ready, 0);
      end
      if (in_valid && in_ready === 1'b1) begin
        last_acc = 1'b1;
        sb.push_back(ref_add(a, b, cin));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Send one beat into an idle pipeline and measure cycles until out_valid.
  task automatic lat_check(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                           input string tag);
    int n;
    a         = x;
    b         = y;
    cin       = c;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, S);
  endtask

  initial begin
    int idx;
    int c;

    // Reset held with a beat offered: nothing accepted, outputs cleared.
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 8'h55;
    b         = 8'h0A;
    cin       = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_in_ready", in_ready, 1);
`ifdef PIPELINED_ADDER_OVF_EN
      chk("rst_ovf", ovf, 0);
`endif
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (3) begin
      tick();
      chk("post_rst_idle", out_valid, 0);
    end

    // Directed arithmetic with latency measurement.
    lat_check(8'hFF, 8'h01, 1'b0, "wrap");
    chk("wrap_sum", sum, 8'h00);
    chk("wrap_cout", cout, 1);
`ifdef PIPELINED_ADDER_OVF_EN
    chk("wrap_ovf", ovf, 0);
`endif
    lat_check(8'h0F, 8'h01, 1'b1, "slice_carry");
    chk("slice_carry_sum", sum, 8'h11);
    chk("slice_carry_cout", cout, 0);
    lat_check(8'h00, 8'h00, 1'b1, "cin_only");
    chk("cin_only_sum", sum, 8'h01);
    chk("cin_only_cout", cout, 0);
`ifdef PIPELINED_ADDER_OVF_EN
    lat_check(8'h7F, 8'h01, 1'b0, "ovf_pos");
    chk("ovf_pos_sum", sum, 8'h80);
    chk("ovf_pos_ovf", ovf, 1);
    chk("ovf_pos_cout", cout, 0);
    lat_check(8'h80, 8'h80, 1'b0, "ovf_neg");
    chk("ovf_neg_sum", sum, 8'h00);
    chk("ovf_neg_ovf", ovf, 1);
    chk("ovf_neg_cout", cout, 1);
`endif

    // Back-pressure: stream 0+0..0+5, consumer stalls on cycles 3-5.
    idx = 0;
    c   = 0;
    while (idx < 6 && c < 40) begin
      out_ready = !(c >= 3 && c <= 5);
      a         = 8'h00;
      b         = W'(idx);
      cin       = 1'b0;
      in_valid  = 1'b1;
      tick();
      if (last_acc) idx++;
      c++;
    end
    chk("bp_all_sent", idx, 6);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (S + 2) tick();
    chk("bp_drained", sb.size(), 0);

    // Bubbles, then a reset with beats in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom);
      tick();
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = W'($urandom);
    b         = W'($urandom);
    tick();
    a = W'($urandom);
    b = W'($urandom);
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (S + 2) begin
      tick();
      chk("rst_flushed", out_valid, 0);
    end
    lat_check(8'h3C, 8'hA5, 1'b1, "after_rst");
    chk("after_rst_sum", sum, 8'hE2);
    chk("after_rst_cout", cout, 0);

    // Randomized traffic with random back-pressure.
    repeat (400) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (S + 2) tick();
    chk("final_drain", sb.size(), 0);
    chk("final_idle", out_valid, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
